// File: rtl/seq_subtractor_if.sv
// Valid/ready operand and result bundle for seq_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface seq_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/seq_subtractor.sv
// Digit-serial subtractor d = a - b - bin, LSB digit first.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module seq_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("seq_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   diff;
  logic [DIGIT-1:0] s;
  logic             brw_n;

  // Widened by one bit so the top bit is the slice's borrow out
  assign diff = {1'b0, a_q[DIGIT-1:0]}
              - {1'b0, b_q[DIGIT-1:0]}
              - {{DIGIT{1'b0}}, brw};
  assign s     = diff[DIGIT-1:0];
  assign brw_n = diff[DIGIT];

`ifdef SUB_OVF_EN
  logic ovf_n;
  // Same as borrow-into-MSB xor borrow-out, from the MSB operand/result bits
  assign ovf_n = (a_q[DIGIT-1] ^ b_q[DIGIT-1])
               & (s[DIGIT-1] ^ a_q[DIGIT-1]);
`endif

  generate
    if (DIGIT == WIDTH) begin : g_one
      assign a_nxt = '0;
      assign b_nxt = '0;
      assign d_nxt = s;
    end else begin : g_shift
      assign a_nxt = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
      assign b_nxt = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      assign d_nxt = {s, bus.d[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.d         <= '0;
      bus.bout      <= 1'b0;
`ifdef SUB_OVF_EN
      bus.ovf       <= 1'b0;
`endif
      a_q           <= '0;
      b_q           <= '0;
      brw           <= 1'b0;
      cnt           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
            brw          <= bus.bin;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          brw   <= brw_n;
          bus.d <= d_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            bus.bout      <= brw_n;
`ifdef SUB_OVF_EN
            bus.ovf       <= ovf_n;
`endif
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor (8/2 main, 12/4 and 8/8 side units).
// Compile with SUB_OVF_EN defined to also check ovf.
module tb_seq_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_subtractor_if #(.WIDTH(8))  bus ();
  seq_subtractor_if #(.WIDTH(12)) bus12 ();
  seq_subtractor_if #(.WIDTH(8))  bus88 ();

  seq_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  seq_subtractor #(.WIDTH(12), .DIGIT(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12.slave)
  );
  seq_subtractor #(.WIDTH(8), .DIGIT(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .bus(bus88.slave)
  );

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_out: got d=%0h with no pending op", bus.d);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_d", bus.d, mon_e.d);
        check("sb_bout", bus.bout, mon_e.bout);
`ifdef SUB_OVF_EN
        check("sb_ovf", bus.ovf, mon_e.ovf);
`endif
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed,
                       input logic eb, input logic eo,
                       input bit push, input bit wait_out,
                       output int l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    if (push) sbq.push_back(exp_t'{ed, eb, eo});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    l = 0;
    if (wait_out)
      while (!bus.out_valid && l < 40) begin
        @(posedge clk);
        #1;
        l++;
      end
  endtask

  task automatic run12(input logic [11:0] a, input logic [11:0] b,
                       input logic bin, input logic [11:0] ed,
                       input logic eb, input logic eo);
    int l;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus12.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus12.a = a;
    bus12.b = b;
    bus12.bin = bin;
    bus12.in_valid = 1'b1;
    @(posedge clk);
    #1 bus12.in_valid = 1'b0;
    l = 0;
    while (!bus12.out_valid && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
    check("w12_latency", l, 3);
    check("w12_d", bus12.d, ed);
    check("w12_bout", bus12.bout, eb);
`ifdef SUB_OVF_EN
    check("w12_ovf", bus12.ovf, eo);
`endif
  endtask

  task automatic run88(input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed,
                       input logic eb, input logic eo);
    int l;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus88.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus88.a = a;
    bus88.b = b;
    bus88.bin = bin;
    bus88.in_valid = 1'b1;
    @(posedge clk);
    #1 bus88.in_valid = 1'b0;
    l = 0;
    while (!bus88.out_valid && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
    check("w8d8_latency", l, 1);
    check("w8d8_d", bus88.d, ed);
    check("w8d8_bout", bus88.bout, eb);
`ifdef SUB_OVF_EN
    check("w8d8_ovf", bus88.ovf, eo);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h0B, 8'h0F, 1'b0, 8'hFC, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 8'h25, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 8'h0A, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    bus12.in_valid = 1'b0;
    bus12.a = '0;
    bus12.b = '0;
    bus12.bin = 1'b0;
    bus12.out_ready = 1'b1;
    bus88.in_valid = 1'b0;
    bus88.a = '0;
    bus88.b = '0;
    bus88.bin = 1'b0;
    bus88.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_d", bus.d, 0);
    check("rst_bout", bus.bout, 0);
`ifdef SUB_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d,
            vecs[i].bout, vecs[i].ovf, 1'b1, 1'b1, lat);
      check("latency", lat, 4);
    end

    // Stall with an ignored in_valid pulse
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(8'h0B, 8'h0F, 1'b0, 8'hFC, 1'b1, 1'b0, 1'b1, 1'b1, lat);
    check("stall_latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 2);
      bus.a = 8'h33;
      bus.b = 8'h11;
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_d", bus.d, 8'hFC);
      check("stall_bout", bus.bout, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_out_valid", bus.out_valid, 0);
    check("handoff_in_ready", bus.in_ready, 1);
    repeat (6) @(posedge clk);
    #1 check("pulse_ignored", bus.out_valid, 0);

    // Abort mid-RUN with reset
    issue(8'hA5, 8'h25, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_d", bus.d, 0);
    check("abort_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("abort_no_out", bus.out_valid, 0);
    issue(8'hA5, 8'h25, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, lat);
    check("post_abort_latency", lat, 4);

    run12(12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1);
    run12(12'h000, 12'hFFF, 1'b1, 12'h000, 1'b1, 1'b0);
    run88(8'h0B, 8'h0F, 1'b0, 8'hFC, 1'b1, 1'b0);
    run88(8'hA5, 8'h25, 1'b1, 8'h7F, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
